stoch_rng_limit: RTL and testbench

STOCH_RNG_LIMIT -- requirements
Module: stoch_rng_limit

---
 rtl/stoch_rng_limit_pkg.sv | 14 +
 rtl/stoch_rng_limit_if.sv | 31 +++
 rtl/stoch_rng_limit_lfsr_scale.sv | 31 +++
 rtl/stoch_rng_limit.sv | 111 +++++++++++
 tb/tb_stoch_rng_limit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/stoch_rng_limit_pkg.sv
// Shared types and default constants for the stochastic RNG / limiter block.
package stoch_rng_limit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } fsm_t;

  // 1 + x^2 + x^3 + x^5 + x^16
  localparam logic [15:0] TAP_MASK_DEF = 16'h8016;
  localparam logic [15:0] SEED_RST_DEF = 16'hACE1;

endpackage

// File: rtl/stoch_rng_limit_if.sv
// Control/data bundle between a bitstream consumer and stoch_rng_limit.
interface stoch_rng_limit_if #(
  parameter int unsigned LFSR_W = 16,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned NCH    = 2,
  parameter int unsigned CNT_W  = 16
);

  logic                   START;
  logic [CNT_W-1:0]       LEN;
  logic                   EN;
  logic                   SEED_LD;
  logic [LFSR_W-1:0]      SEED;
  logic                   LIMIT_LD;
  logic [NCH*OUT_W-1:0]   LIMIT;
  logic [NCH*OUT_W-1:0]   OUT;
  logic                   VALID;
  logic                   DONE;
  logic                   LOCKUP;

  modport master (
    output START, LEN, EN, SEED_LD, SEED, LIMIT_LD, LIMIT,
    input  OUT, VALID, DONE, LOCKUP
  );

  modport slave (
    input  START, LEN, EN, SEED_LD, SEED, LIMIT_LD, LIMIT,
    output OUT, VALID, DONE, LOCKUP
  );

endinterface

// File: rtl/stoch_rng_limit_lfsr_scale.sv
// One channel: multiply a raw LFSR slice by its limit and keep the upper half.
module lfsr_scale #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] raw,
  input  logic [W-1:0] limit,
  output logic [W-1:0] out_q
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_hi;

  // Full-width product, truncated (no rounding) so the result stays below limit.
  always_comb begin
    prod    = {{W{1'b0}}, raw} * {{W{1'b0}}, limit};
    prod_hi = W'(prod >> W);
  end

  // Register the scaled sample only on a step; otherwise hold the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (load) begin
      out_q <= prod_hi;
    end
  end

endmodule

// File: rtl/stoch_rng_limit.sv
// LFSR-driven multi-channel random sample generator with per-channel scaling
// and a length-limited run controller.
module stoch_rng_limit
  import stoch_rng_limit_pkg::*;
#(
  parameter int unsigned       LFSR_W   = 16,
  parameter int unsigned       OUT_W    = 8,
  parameter int unsigned       NCH      = 2,
  parameter logic [LFSR_W-1:0] TAP_MASK = TAP_MASK_DEF,
  parameter logic [LFSR_W-1:0] SEED_RST = SEED_RST_DEF,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic             TRIG,
  input  logic             RESET,
  stoch_rng_limit_if.slave bus
);

  if (NCH * OUT_W > LFSR_W) begin : g_bad_width
    $error("stoch_rng_limit: NCH*OUT_W (%0d) exceeds LFSR_W (%0d)", NCH * OUT_W, LFSR_W);
  end
  if (TAP_MASK[LFSR_W-1] != 1'b1) begin : g_bad_taps
    $error("stoch_rng_limit: TAP_MASK must include bit LFSR_W-1");
  end

  logic [LFSR_W-1:0]    lfsr_q;
  logic [NCH*OUT_W-1:0] limit_q;
  logic [NCH*OUT_W-1:0] out_w;
  logic [CNT_W-1:0]     cnt_q;
  fsm_t                 fsm_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 lockup_q;
  logic                 fb;
  logic                 step;

  // Feedback bit and step qualifier; a seed load always wins over a step.
  always_comb begin
    fb   = ^(lfsr_q & TAP_MASK);
    step = (fsm_q == ST_RUN) && bus.EN && !bus.SEED_LD;
  end

  // Run controller, LFSR state, limit register and status flags.
  always_ff @(posedge TRIG or negedge RESET) begin
    if (!RESET) begin
      lfsr_q   <= SEED_RST;
      limit_q  <= '1;
      cnt_q    <= '0;
      fsm_q    <= ST_IDLE;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.LIMIT_LD) begin
        limit_q <= bus.LIMIT;
      end
      if (bus.SEED_LD) begin
        // An all-zero seed would lock the LFSR; substitute and flag it.
        if (bus.SEED == '0) begin
          lfsr_q   <= SEED_RST;
          lockup_q <= 1'b1;
        end else begin
          lfsr_q <= bus.SEED;
        end
        fsm_q <= ST_IDLE;
      end else begin
        case (fsm_q)
          ST_IDLE: begin
            if (bus.START && (bus.LEN != '0)) begin
              cnt_q <= bus.LEN;
              fsm_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (step) begin
              lfsr_q  <= {lfsr_q[LFSR_W-2:0], fb};
              valid_q <= 1'b1;
              cnt_q   <= cnt_q - CNT_W'(1);
              if (cnt_q == CNT_W'(1)) begin
                fsm_q <= ST_FIN;
              end
            end
          end
          ST_FIN: begin
            done_q <= 1'b1;
            fsm_q  <= ST_IDLE;
          end
          default: fsm_q <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    lfsr_scale #(.W(OUT_W)) u_scale (
      .clk   (TRIG),
      .rst_n (RESET),
      .load  (step),
      .raw   (lfsr_q[k*OUT_W +: OUT_W]),
      .limit (limit_q[k*OUT_W +: OUT_W]),
      .out_q (out_w[k*OUT_W +: OUT_W])
    );
  end

  assign bus.OUT    = out_w;
  assign bus.VALID  = valid_q;
  assign bus.DONE   = done_q;
  assign bus.LOCKUP = lockup_q;

endmodule

// File: tb/tb_stoch_rng_limit.sv
// Directed bench for stoch_rng_limit at default parameters.
module tb_stoch_rng_limit;
  import stoch_rng_limit_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stoch_rng_limit_if #(.LFSR_W(16), .OUT_W(8), .NCH(2), .CNT_W(16)) bus ();

  stoch_rng_limit #(
    .LFSR_W(16), .OUT_W(8), .NCH(2),
    .TAP_MASK(16'h8016), .SEED_RST(16'hACE1), .CNT_W(16)
  ) dut (
    .TRIG  (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], ^(s & 16'h8016)};
  endfunction

  function automatic logic [15:0] scale(input logic [15:0] s, input logic [15:0] l);
    logic [15:0] a, b;
    a = {8'h00, s[15:8]} * {8'h00, l[15:8]};
    b = {8'h00, s[7:0]}  * {8'h00, l[7:0]};
    return {a[15:8], b[15:8]};
  endfunction

  logic [15:0] model, lim, expo, start_s;
  int          vcnt, period;
  logic [7:0]  maxb;
  logic        done_seen;
  logic        en_b;

  initial begin
    bus.START = 1'b0; bus.LEN = '0; bus.EN = 1'b0; bus.SEED_LD = 1'b0;
    bus.SEED = '0; bus.LIMIT_LD = 1'b0; bus.LIMIT = '0;

    // Reset state
    #12;
    check("rst_out",    bus.OUT, 16'h0000);
    check("rst_valid",  bus.VALID, 1'b0);
    check("rst_done",   bus.DONE, 1'b0);
    check("rst_lockup", bus.LOCKUP, 1'b0);
    check("rst_state",  dut.lfsr_q, 16'hACE1);
    check("rst_limit",  dut.limit_q, 16'hFFFF);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single-sample run with hand-computed result
    bus.SEED_LD = 1'b1; bus.SEED = 16'h8000; bus.LIMIT_LD = 1'b1; bus.LIMIT = 16'h8080;
    cyc();
    bus.SEED_LD = 1'b0; bus.LIMIT_LD = 1'b0;
    check("seed_8000", dut.lfsr_q, 16'h8000);
    bus.START = 1'b1; bus.LEN = 16'd1; bus.EN = 1'b1;
    cyc();
    bus.START = 1'b0;
    check("one_pre_valid", bus.VALID, 1'b0);
    cyc();
    check("one_valid", bus.VALID, 1'b1);
    check("one_out",   bus.OUT, 16'h4000);
    check("one_nodone", bus.DONE, 1'b0);
    cyc();
    check("one_done",  bus.DONE, 1'b1);
    check("one_vlow",  bus.VALID, 1'b0);
    check("one_state", dut.lfsr_q, 16'h0001);
    check("one_hold",  bus.OUT, 16'h4000);
    bus.EN = 1'b0;
    cyc();
    check("one_done_pulse", bus.DONE, 1'b0);

    // Zero seed substitution and sticky lockup
    bus.SEED_LD = 1'b1; bus.SEED = 16'h0000;
    cyc();
    check("zero_lockup", bus.LOCKUP, 1'b1);
    check("zero_state",  dut.lfsr_q, 16'hACE1);
    bus.SEED = 16'h1234;
    cyc();
    bus.SEED_LD = 1'b0;
    check("sticky_lockup", bus.LOCKUP, 1'b1);
    check("reseed_state",  dut.lfsr_q, 16'h1234);

    // LEN=4 with stalls; a START during the run must be ignored
    model = 16'h1234; lim = 16'h8080; expo = 16'h4000; vcnt = 0;
    bus.START = 1'b1; bus.LEN = 16'd4;
    cyc();
    bus.START = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en_b = (i % 2 == 0);
      bus.EN = en_b;
      bus.START = (i == 3);
      cyc();
      bus.START = 1'b0;
      if (en_b) begin
        expo  = scale(model, lim);
        model = lstep(model);
      end
      vcnt += int'(bus.VALID);
      check($sformatf("stall_valid%0d", i), bus.VALID, en_b);
      check($sformatf("stall_out%0d", i), bus.OUT, expo);
      check($sformatf("stall_done%0d", i), bus.DONE, 1'b0);
    end
    bus.EN = 1'b0;
    cyc();
    check("stall_vcnt",  vcnt, 4);
    check("stall_done",  bus.DONE, 1'b1);
    check("stall_state", dut.lfsr_q, model);
    cyc();
    check("stall_idle",  dut.fsm_q, ST_IDLE);

    // Seed load aborts a LEN=5 run after two samples
    bus.START = 1'b1; bus.LEN = 16'd5; bus.EN = 1'b1;
    cyc();
    bus.START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      expo  = scale(model, lim);
      model = lstep(model);
      check($sformatf("abort_out%0d", i), bus.OUT, expo);
    end
    bus.SEED_LD = 1'b1; bus.SEED = 16'hBEEF;
    cyc();
    bus.SEED_LD = 1'b0;
    check("abort_valid", bus.VALID, 1'b0);
    check("abort_state", dut.lfsr_q, 16'hBEEF);
    check("abort_fsm",   dut.fsm_q, ST_IDLE);
    check("abort_hold",  bus.OUT, expo);
    done_seen = bus.DONE;
    for (int i = 0; i < 3; i++) begin
      cyc();
      done_seen = done_seen | bus.DONE | bus.VALID;
    end
    check("abort_quiet", done_seen, 1'b0);
    model = 16'hBEEF;
    bus.START = 1'b1; bus.LEN = 16'd5;
    cyc();
    bus.START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expo  = scale(model, lim);
      model = lstep(model);
      check($sformatf("rerun_valid%0d", i), bus.VALID, 1'b1);
      check($sformatf("rerun_out%0d", i), bus.OUT, expo);
    end
    cyc();
    check("rerun_done", bus.DONE, 1'b1);
    bus.EN = 1'b0;

    // Zero limit gives zero samples, VALID still pulses
    bus.LIMIT_LD = 1'b1; bus.LIMIT = 16'h0000;
    cyc();
    bus.LIMIT_LD = 1'b0;
    bus.START = 1'b1; bus.LEN = 16'd3; bus.EN = 1'b1;
    cyc();
    bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("lim0_valid%0d", i), bus.VALID, 1'b1);
      check($sformatf("lim0_out%0d", i), bus.OUT, 16'h0000);
    end
    cyc();
    check("lim0_done", bus.DONE, 1'b1);
    bus.EN = 1'b0;

    // Full period with maximal limit
    bus.LIMIT_LD = 1'b1; bus.LIMIT = 16'hFFFF;
    cyc();
    bus.LIMIT_LD = 1'b0;
    bus.START = 1'b1; bus.LEN = 16'd65535; bus.EN = 1'b1;
    cyc();
    bus.START = 1'b0;
    start_s = dut.lfsr_q; period = 0; maxb = 8'h00; vcnt = 0;
    for (int i = 1; i <= 65535; i++) begin
      cyc();
      vcnt += int'(bus.VALID);
      if (bus.OUT[15:8] > maxb) maxb = bus.OUT[15:8];
      if (bus.OUT[7:0]  > maxb) maxb = bus.OUT[7:0];
      if (period == 0 && dut.lfsr_q == start_s) period = i;
    end
    check("period",      period, 65535);
    check("period_max",  maxb, 8'hFE);
    check("period_vcnt", vcnt, 65535);
    cyc();
    check("period_done", bus.DONE, 1'b1);

    // Asynchronous reset mid-run, then replay from SEED_RST
    bus.START = 1'b1; bus.LEN = 16'd4;
    cyc();
    bus.START = 1'b0;
    cyc();
    cyc();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out",    bus.OUT, 16'h0000);
    check("arst_valid",  bus.VALID, 1'b0);
    check("arst_state",  dut.lfsr_q, 16'hACE1);
    check("arst_lockup", bus.LOCKUP, 1'b0);
    check("arst_fsm",    dut.fsm_q, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("arst_nodone", bus.DONE, 1'b0);
    bus.START = 1'b1; bus.LEN = 16'd3;
    cyc();
    bus.START = 1'b0;
    cyc();
    check("replay_out0", bus.OUT, 16'hABE0);
    cyc();
    check("replay_out1", bus.OUT, 16'h58C2);
    cyc();
    check("replay_out2", bus.OUT, scale(lstep(16'h59C3), 16'hFFFF));
    cyc();
    check("replay_done", bus.DONE, 1'b1);
    bus.EN = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
